// File: rtl/seg_pkg.sv
// Shared types and constants for the 7-segment scan controller.
package seg_pkg;

    typedef logic [3:0] bcd_t;

    localparam bcd_t BCD_MAX = 4'd9;

    typedef enum logic [0:0] {
        IDLE,
        SCAN
    } scan_state_e;

    function automatic logic bcd_invalid(input bcd_t code);
        return code > BCD_MAX;
    endfunction

endpackage

// File: rtl/seg_prescaler.sv
// Digit-slot prescaler: counts 0..DIV-1 and flags the last cycle of each slot.
module seg_prescaler #(
    parameter int unsigned DIV   = 1000,
    parameter int unsigned DIV_W = $clog2(DIV)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_restart,
    output logic             o_tick,
    output logic [DIV_W-1:0] o_cnt
);

    logic [DIV_W-1:0] r_cnt;
    logic             w_last;

    assign w_last = (r_cnt == DIV_W'(DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_restart || w_last) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + DIV_W'(1);
        end
    end

    assign o_tick = w_last;
    assign o_cnt  = r_cnt;

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed 7-segment scan controller with frame-boundary commit of pending BCD frames.
// Optional leading-zero suppression is compiled in when SEG_LZ_BLANK_EN is defined.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int unsigned N_DIG = 4,
    parameter int unsigned DIV   = 1000,
    parameter int unsigned DIV_W = $clog2(DIV),
    parameter int unsigned IDX_W = $clog2(N_DIG)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [4*N_DIG-1:0] in_data,
    output logic [3:0]         dec_b,
    output logic [N_DIG-1:0]   dig_sel,
    output logic               seg_blank,
    output logic               frame_done,
    output logic               code_err,
    input  logic               err_clr
);

    scan_state_e        r_state, w_state_nxt;
    logic [IDX_W-1:0]   r_idx, w_idx_nxt;
    logic [4*N_DIG-1:0] r_active, w_active_nxt;
    logic [4*N_DIG-1:0] r_pend;
    logic               r_pend_vld, w_pend_vld_nxt;
    logic [N_DIG-1:0]   r_dig_sel, w_dig_sel_nxt;
    bcd_t               r_dec_b, w_dec_b_nxt;
    logic               r_seg_blank, w_seg_blank_nxt;
    logic               r_frame_done, w_frame_done_nxt;
    logic               r_code_err, w_code_err_nxt;

    logic               w_tick;
    logic [DIV_W-1:0]   w_cnt;
    logic               w_accept;
    logic               w_wrap;
    logic               w_first;
    logic               w_lz;

    // Held in restart while idle so the first slot after a load starts at count 0.
    seg_prescaler #(
        .DIV   (DIV),
        .DIV_W (DIV_W)
    ) u_prescaler (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_restart (r_state == IDLE),
        .o_tick    (w_tick),
        .o_cnt     (w_cnt)
    );

    assign w_accept = in_valid && !r_pend_vld;
    assign w_wrap   = w_tick && (r_idx == IDX_W'(N_DIG - 1));

    always_comb begin
        w_state_nxt    = r_state;
        w_idx_nxt      = r_idx;
        w_active_nxt   = r_active;
        w_pend_vld_nxt = r_pend_vld;
        w_first        = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nxt  = SCAN;
                    w_idx_nxt    = '0;
                    w_active_nxt = in_data;
                    w_first      = 1'b1;
                end
            end
            SCAN: begin
                if (w_accept) begin
                    w_pend_vld_nxt = 1'b1;
                end
                if (w_tick) begin
                    w_first   = 1'b1;
                    w_idx_nxt = w_wrap ? '0 : r_idx + IDX_W'(1);
                    if (w_wrap && r_pend_vld) begin
                        w_active_nxt   = r_pend;
                        w_pend_vld_nxt = 1'b0;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

`ifdef SEG_LZ_BLANK_EN
    // Blank when this digit and every more significant digit are zero; digit 0 always shows.
    always_comb begin
        w_lz = (w_idx_nxt != '0);
        for (int k = 0; k < int'(N_DIG); k++) begin
            if (k >= int'(w_idx_nxt) && w_active_nxt[4*k +: 4] != 4'd0) begin
                w_lz = 1'b0;
            end
        end
    end
`else
    assign w_lz = 1'b0;
`endif

    // Outputs are precomputed from next-state so they change together with the slot.
    always_comb begin
        w_dig_sel_nxt = '0;
        w_dec_b_nxt   = '0;
        if (w_state_nxt == SCAN) begin
            w_dig_sel_nxt = N_DIG'(1) << w_idx_nxt;
            w_dec_b_nxt   = w_active_nxt[4*w_idx_nxt +: 4];
        end
        w_seg_blank_nxt  = (w_state_nxt == IDLE) || w_first || bcd_invalid(w_dec_b_nxt) || w_lz;
        w_frame_done_nxt = (r_state == SCAN) && (w_cnt == DIV_W'(DIV - 2))
                           && (r_idx == IDX_W'(N_DIG - 1));
        w_code_err_nxt   = ((r_state == SCAN) && (w_cnt == '0) && bcd_invalid(r_dec_b))
                           || (r_code_err && !err_clr);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_idx        <= '0;
            r_active     <= '0;
            r_pend       <= '0;
            r_pend_vld   <= 1'b0;
            r_dig_sel    <= '0;
            r_dec_b      <= '0;
            r_seg_blank  <= 1'b1;
            r_frame_done <= 1'b0;
            r_code_err   <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_idx        <= w_idx_nxt;
            r_active     <= w_active_nxt;
            r_pend_vld   <= w_pend_vld_nxt;
            r_dig_sel    <= w_dig_sel_nxt;
            r_dec_b      <= w_dec_b_nxt;
            r_seg_blank  <= w_seg_blank_nxt;
            r_frame_done <= w_frame_done_nxt;
            r_code_err   <= w_code_err_nxt;
            if (r_state == SCAN && w_accept) begin
                r_pend <= in_data;
            end
        end
    end

    assign in_ready   = !r_pend_vld;
    assign dig_sel    = r_dig_sel;
    assign dec_b      = r_dec_b;
    assign seg_blank  = r_seg_blank;
    assign frame_done = r_frame_done;
    assign code_err   = r_code_err;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with N_DIG=4, DIV=4.
module tb_seg_scan_ctrl;

    localparam int N_DIG = 4;
    localparam int DIV   = 4;
`ifdef SEG_LZ_BLANK_EN
    localparam bit LZ = 1'b1;
`else
    localparam bit LZ = 1'b0;
`endif

    logic        clk      = 1'b0;
    logic        rst_n    = 1'b1;
    logic        in_valid = 1'b0;
    logic        err_clr  = 1'b0;
    logic [15:0] in_data  = '0;
    logic        in_ready;
    logic [3:0]  dec_b;
    logic [3:0]  dig_sel;
    logic        seg_blank;
    logic        frame_done;
    logic        code_err;

    int n_cmp = 0;
    int n_err = 0;

    seg_scan_ctrl #(
        .N_DIG (N_DIG),
        .DIV   (DIV)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .dec_b      (dec_b),
        .dig_sel    (dig_sel),
        .seg_blank  (seg_blank),
        .frame_done (frame_done),
        .code_err   (code_err),
        .err_clr    (err_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_dark(input string tag);
        chk({tag, ".sel"}, 32'(dig_sel), 32'd0);
        chk({tag, ".blank"}, 32'(seg_blank), 32'd1);
        chk({tag, ".dec"}, 32'(dec_b), 32'd0);
        chk({tag, ".rdy"}, 32'(in_ready), 32'd1);
        chk({tag, ".err"}, 32'(code_err), 32'd0);
        chk({tag, ".fdone"}, 32'(frame_done), 32'd0);
    endtask

    // Called at the negedge of a slot's first cycle; walks the whole slot.
    // Inputs set before the call are held for that first cycle only.
    task automatic slot(input string tag, input int idx, input int code, input bit blank_all,
                        input bit rdy0, input bit rdy_rest, input bit err0, input bit err_rest);
        for (int c = 0; c < DIV; c++) begin
            chk({tag, ".sel"}, 32'(dig_sel), 32'(1 << idx));
            chk({tag, ".dec"}, 32'(dec_b), 32'(code));
            chk({tag, ".blank"}, 32'(seg_blank), (c == 0) ? 32'd1 : 32'(blank_all));
            chk({tag, ".rdy"}, 32'(in_ready), (c == 0) ? 32'(rdy0) : 32'(rdy_rest));
            chk({tag, ".err"}, 32'(code_err), (c == 0) ? 32'(err0) : 32'(err_rest));
            chk({tag, ".fdone"}, 32'(frame_done), 32'(idx == N_DIG - 1 && c == DIV - 1));
            @(negedge clk);
            in_valid = 1'b0;
            err_clr  = 1'b0;
        end
    endtask

    initial begin
        #2 rst_n = 1'b0;
        @(negedge clk);
        chk_dark("rst");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk_dark("idle");

        // First load straight into the active frame
        in_valid = 1'b1;
        in_data  = 16'h1234;
        @(negedge clk);
        in_valid = 1'b0;
        slot("A0", 0, 4, 0, 1, 1, 0, 0);
        slot("A1", 1, 3, 0, 1, 1, 0, 0);
        slot("A2", 2, 2, 0, 1, 1, 0, 0);
        slot("A3", 3, 1, 0, 1, 1, 0, 0);

        // Mid-frame load while idx=1; a second offer while not ready is ignored
        slot("B0", 0, 4, 0, 1, 1, 0, 0);
        in_valid = 1'b1;
        in_data  = 16'h5678;
        slot("B1", 1, 3, 0, 1, 0, 0, 0);
        in_valid = 1'b1;
        in_data  = 16'h9999;
        slot("B2", 2, 2, 0, 0, 0, 0, 0);
        slot("B3", 3, 1, 0, 0, 0, 0, 0);

        in_valid = 1'b1;
        in_data  = 16'h12A4;
        slot("C0", 0, 8, 0, 1, 0, 0, 0);
        slot("C1", 1, 7, 0, 0, 0, 0, 0);
        slot("C2", 2, 6, 0, 0, 0, 0, 0);
        slot("C3", 3, 5, 0, 0, 0, 0, 0);

        // Invalid code: slot 1 blanked throughout, sticky error
        slot("D0", 0, 4, 0, 1, 1, 0, 0);
        slot("D1", 1, 'hA, 1, 1, 1, 0, 1);
        slot("D2", 2, 2, 0, 1, 1, 1, 1);
        slot("D3", 3, 1, 0, 1, 1, 1, 1);

        // Clear works on a clean slot; set beats a simultaneous clear
        err_clr = 1'b1;
        slot("E0", 0, 4, 0, 1, 1, 1, 0);
        err_clr = 1'b1;
        slot("E1", 1, 'hA, 1, 1, 1, 0, 1);
        in_valid = 1'b1;
        in_data  = 16'h0070;
        slot("E2", 2, 2, 0, 1, 0, 1, 1);
        slot("E3", 3, 1, 0, 0, 0, 1, 1);

        in_valid = 1'b1;
        in_data  = 16'h0000;
        slot("F0", 0, 0, 0, 1, 0, 1, 1);
        slot("F1", 1, 7, 0, 0, 0, 1, 1);
        slot("F2", 2, 0, LZ, 0, 0, 1, 1);
        slot("F3", 3, 0, LZ, 0, 0, 1, 1);

        err_clr  = 1'b1;
        in_valid = 1'b1;
        in_data  = 16'h1234;
        slot("G0", 0, 0, 0, 1, 0, 1, 0);
        slot("G1", 1, 0, LZ, 0, 0, 0, 0);
        slot("G2", 2, 0, LZ, 0, 0, 0, 0);
        slot("G3", 3, 0, LZ, 0, 0, 0, 0);

        // Reset during slot 2 with a frame pending
        slot("H0", 0, 4, 0, 1, 1, 0, 0);
        in_valid = 1'b1;
        in_data  = 16'h9876;
        slot("H1", 1, 3, 0, 1, 0, 0, 0);
        chk("H2.sel", 32'(dig_sel), 32'b0100);
        #2 rst_n = 1'b0;
        #1;
        chk_dark("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk_dark("post_rst");

        in_valid = 1'b1;
        in_data  = 16'h4321;
        @(negedge clk);
        in_valid = 1'b0;
        slot("R0", 0, 1, 0, 1, 1, 0, 0);
        slot("R1", 1, 2, 0, 1, 1, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
